dcache_controller: RTL

//   Sequences the pipeline's data cache: direct-mapped, write-back, write-allocate, one clock domain.

---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_sram.sv | 47 ++++
 rtl/dcache_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-field helpers for the data cache.
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int IDX_W    = 5;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;
    localparam int WORD_W   = 32;
    localparam int WSEL_W   = OFFSET_W - 2;
    localparam int LINES    = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MISS      = 3'd1,
        WRITEBACK = 3'd2,
        READMISS  = 3'd3,
        REFILL    = 3'd4
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: IDX_W];
    endfunction

    // Word select within the line; the byte offset bits [1:0] are dropped.
    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage for the direct-mapped cache.
// Reads are asynchronous, writes are synchronous; only valid/dirty are reset.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wr_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_dirty
);

    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [LINE_W-1:0] lines [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= wr_dirty;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[idx]  <= wr_tag;
            lines[idx] <= wr_data;
        end
    end

    assign rd_tag   = tags[idx];
    assign rd_data  = lines[idx];
    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   p1_addr_i,
    input  logic [WORD_W-1:0]   p1_data_i,
    input  logic                p1_MemRead_i,
    input  logic                p1_MemWrite_i,
    output logic [WORD_W-1:0]   p1_data_o,
    output logic                p1_stall_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);

    state_t state, next_state;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic              req;
    logic              hit;
    logic              store_hit;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_dirty;
    logic [LINE_W-1:0] merged;
    logic [LINE_W-1:0] refill_buf;
    logic              wr_en;
    logic [LINE_W-1:0] wr_data;
    logic              wr_dirty;
    logic              unused_bits;

    assign tag         = addr_tag(p1_addr_i);
    assign idx         = addr_idx(p1_addr_i);
    assign word        = addr_word(p1_addr_i);
    assign unused_bits = &{1'b0, p1_addr_i[1:0]};

    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign hit        = rd_valid & (rd_tag == tag);
    assign store_hit  = (state == IDLE) & p1_MemWrite_i & hit;
    assign p1_stall_o = (req & ~hit) | (state != IDLE);
    assign p1_data_o  = (req & ~p1_stall_o) ? rd_data[word*WORD_W +: WORD_W] : '0;

    always_comb begin
        merged = rd_data;
        merged[word*WORD_W +: WORD_W] = p1_data_i;
    end

    // A refill installs a clean line; a store hit rewrites the line with the merged word.
    assign wr_en    = store_hit | (state == REFILL);
    assign wr_data  = (state == REFILL) ? refill_buf : merged;
    assign wr_dirty = (state != REFILL);

    dcache_sram u_sram (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .idx      (idx),
        .wr_en    (wr_en),
        .wr_tag   (tag),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            refill_buf <= '0;
        end else if ((state == READMISS) && mem_ack_i) begin
            refill_buf <= mem_data_i;
        end
    end

    // Memory outputs are decoded from state so a reset drops mem_enable_o immediately.
    always_comb begin
        next_state   = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (req && !hit) next_state = MISS;
            end
            MISS: begin
                next_state = (rd_valid && rd_dirty) ? WRITEBACK : READMISS;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, idx, {OFFSET_W{1'b0}}};
                mem_data_o   = rd_data;
                if (mem_ack_i) next_state = READMISS;
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) next_state = REFILL;
            end
            REFILL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        just_refilled;

    // The access completing right after a refill is part of the miss, not a hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            just_refilled <= 1'b0;
        end else begin
            just_refilled <= (state == REFILL);
            if ((state == IDLE) && req && hit && !just_refilled && (hit_cnt != 32'hFFFF_FFFF))
                hit_cnt <= hit_cnt + 32'd1;
            if ((state == IDLE) && req && !hit && (miss_cnt != 32'hFFFF_FFFF))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
